// File: rtl/cordic_sincos_pkg.sv
// Shared fixed-point constants and FSM encoding for the rotation-mode CORDIC sin/cos engine.
`ifndef CORDIC_SINCOS_PKG_SV
`define CORDIC_SINCOS_PKG_SV
package cordic_sincos_pkg;

  localparam int unsigned FRAC_BITS = 16;
  localparam logic signed [31:0] DEG90  = 32'sd90 <<< FRAC_BITS;
  localparam logic signed [31:0] DEG180 = 32'sd180 <<< FRAC_BITS;
  // 0.607252935 in 16.16: pre-compensates the gain of the micro-rotations
  localparam int KINIT = 39797;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_FIN
  } state_e;

  function automatic logic signed [31:0] neg_if(input logic n, input logic signed [31:0] v);
    return n ? -v : v;
  endfunction

endpackage
`endif

// File: rtl/xita_tan_lut.sv
// atan(2^-i) table in signed 16.16 degrees for i = 0..20; registered on the falling clock edge.
module xita_tan_lut (
  input  logic               clk,
  input  logic [4:0]         i,
  output logic signed [31:0] xita
);

  logic signed [31:0] xita_d;

  always_comb begin
    xita_d = 32'sd0;
    unique case (i)
      5'd0:    xita_d = 32'sd2949120;
      5'd1:    xita_d = 32'sd1740967;
      5'd2:    xita_d = 32'sd919879;
      5'd3:    xita_d = 32'sd466945;
      5'd4:    xita_d = 32'sd234379;
      5'd5:    xita_d = 32'sd117305;
      5'd6:    xita_d = 32'sd58666;
      5'd7:    xita_d = 32'sd29335;
      5'd8:    xita_d = 32'sd14668;
      5'd9:    xita_d = 32'sd7334;
      5'd10:   xita_d = 32'sd3667;
      5'd11:   xita_d = 32'sd1833;
      5'd12:   xita_d = 32'sd917;
      5'd13:   xita_d = 32'sd458;
      5'd14:   xita_d = 32'sd229;
      5'd15:   xita_d = 32'sd115;
      5'd16:   xita_d = 32'sd57;
      5'd17:   xita_d = 32'sd29;
      5'd18:   xita_d = 32'sd14;
      5'd19:   xita_d = 32'sd7;
      5'd20:   xita_d = 32'sd4;
      default: xita_d = 32'sd0;
    endcase
  end

  // Falling-edge register: the value for the current index is ready by the next rising edge.
  always_ff @(negedge clk) begin
    xita <= xita_d;
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: signed 16.16 angle in degrees to signed 16.16 sine and cosine.
module cordic_sincos
  import cordic_sincos_pkg::*;
#(
  parameter int unsigned ITER  = 16,
  parameter int          KINIT = cordic_sincos_pkg::KINIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] angle,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic signed [31:0] sin_o,
  output logic signed [31:0] cos_o
);

  localparam logic [4:0]         LAST   = 5'(ITER - 1);
  localparam logic signed [31:0] KINIT_C = 32'(KINIT);

  state_e             state_q, state_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               err_pend_q, err_pend_d;
  logic               busy_d, done_d, err_d;
  logic signed [31:0] sin_d, cos_d;

  logic signed [31:0] xita;
  logic signed [31:0] x_sh, y_sh;

  xita_tan_lut u_lut (
    .clk  (clk),
    .i    (cnt_q),
    .xita (xita)
  );

  assign x_sh = x_q >>> cnt_q;
  assign y_sh = y_q >>> cnt_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    err_pend_d = err_pend_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;
    sin_d      = sin_o;
    cos_d      = cos_o;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (angle > DEG180 || angle < -DEG180) begin
            err_pend_d = 1'b1;
            state_d    = S_FIN;
          end else begin
            err_pend_d = 1'b0;
            // Fold into [-90, +90] where CORDIC converges; the sign is restored at the end.
            if (angle > DEG90) begin
              z_d   = angle - DEG180;
              neg_d = 1'b1;
            end else if (angle < -DEG90) begin
              z_d   = angle + DEG180;
              neg_d = 1'b1;
            end else begin
              z_d   = angle;
              neg_d = 1'b0;
            end
            x_d     = KINIT_C;
            y_d     = 32'sd0;
            cnt_d   = 5'd0;
            state_d = S_ROT;
          end
        end
      end

      S_ROT: begin
        if (!z_q[31]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - xita;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + xita;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = err_pend_q;
        sin_d   = err_pend_q ? 32'sd0 : neg_if(neg_q, y_q);
        cos_d   = err_pend_q ? 32'sd0 : neg_if(neg_q, x_q);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= 32'sd0;
      y_q        <= 32'sd0;
      z_q        <= 32'sd0;
      cnt_q      <= 5'd0;
      neg_q      <= 1'b0;
      err_pend_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sin_o      <= 32'sd0;
      cos_o      <= 32'sd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      err_pend_q <= err_pend_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      sin_o      <= sin_d;
      cos_o      <= cos_d;
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: trigonometric reference model, queued expectations, monitor.
module tb_cordic_sincos;

  localparam int unsigned ITER = 16;
  localparam int          ONE_DEG = 65536;
  localparam int          D180 = 180 * ONE_DEG;
  localparam real         PI = 3.14159265358979;
  localparam longint      TOL_MILLI = 16000;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [31:0] angle;
  logic               busy;
  logic               done;
  logic               err;
  logic signed [31:0] sin_o;
  logic signed [31:0] cos_o;

  typedef struct {
    bit     is_err;
    longint sin_milli;  // ideal * 65536 * 1000
    longint cos_milli;
    int     due;        // cycle count at which done must be seen
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  cordic_sincos #(
    .ITER (ITER)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .angle (angle),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .sin_o (sin_o),
    .cos_o (cos_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain trigonometry on the angle in degrees.
  function automatic exp_t model(input int a);
    exp_t e;
    real  rad;
    e.is_err = (a > D180) || (a < -D180);
    if (e.is_err) begin
      e.sin_milli = 0;
      e.cos_milli = 0;
    end else begin
      rad = (real'(a) / 65536.0) * PI / 180.0;
      e.sin_milli = longint'($sin(rad) * 65536.0 * 1000.0);
      e.cos_milli = longint'($cos(rad) * 65536.0 * 1000.0);
    end
    e.due = 0;
    return e;
  endfunction

  task automatic issue(input int a);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    angle = a;
    e = model(a);
    e.due = cyc + (e.is_err ? 2 : int'(ITER) + 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("done_timeout", sb.size() == 0, sb.size(), 0);
    sb.delete();
    @(posedge clk);
  endtask

  task automatic pulse_start(input int a);
    @(posedge clk);
    #1;
    start = 1'b1;
    angle = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("spurious_done", sb.size() != 0, 1, 0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc == e.due, cyc, e.due);
        chk("err", err == e.is_err, err, e.is_err);
        if (e.is_err) begin
          chk("err_sin_zero", sin_o == 0, sin_o, 0);
          chk("err_cos_zero", cos_o == 0, cos_o, 0);
        end else begin
          chk("sin", labs(longint'(sin_o) * 1000 - e.sin_milli) <= TOL_MILLI,
              sin_o, e.sin_milli / 1000);
          chk("cos", labs(longint'(cos_o) * 1000 - e.cos_milli) <= TOL_MILLI,
              cos_o, e.cos_milli / 1000);
        end
        chk("busy_low_at_done", busy == 1'b0, busy, 0);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    angle = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy == 1'b0, busy, 0);
    chk("rst_done", done == 1'b0, done, 0);
    chk("rst_err", err == 1'b0, err, 0);
    chk("rst_sin", sin_o == 0, sin_o, 0);
    chk("rst_cos", cos_o == 0, cos_o, 0);

    // Directed angles including fold and range boundaries
    issue(0);                  wait_idle();
    issue(30 * ONE_DEG);       wait_idle();
    issue(150 * ONE_DEG);      wait_idle();
    issue(-90 * ONE_DEG);      wait_idle();
    issue(90 * ONE_DEG);       wait_idle();
    issue(200 * ONE_DEG);      wait_idle();
    issue(45 * ONE_DEG);       wait_idle();
    issue(D180);               wait_idle();
    issue(-D180);              wait_idle();
    issue(D180 + 1);           wait_idle();
    issue(-D180 - 1);          wait_idle();
    issue(-150 * ONE_DEG);     wait_idle();
    issue(90 * ONE_DEG + 1);   wait_idle();
    issue(-90 * ONE_DEG - 1);  wait_idle();

    // Starts while busy must be ignored; the monitor flags any extra done.
    issue(20 * ONE_DEG);
    repeat (1) @(posedge clk);
    pulse_start(-70 * ONE_DEG);
    repeat (5) @(posedge clk);
    pulse_start(200 * ONE_DEG);
    wait_idle();
    repeat (ITER + 4) @(posedge clk);

    // Reset mid-run abandons the computation.
    issue(70 * ONE_DEG);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy == 1'b0, busy, 0);
    chk("midrst_done", done == 1'b0, done, 0);
    chk("midrst_sin", sin_o == 0, sin_o, 0);
    chk("midrst_cos", cos_o == 0, cos_o, 0);
    repeat (ITER + 4) @(posedge clk);
    issue(60 * ONE_DEG);       wait_idle();

    // Random in-range and occasional out-of-range angles
    for (int k = 0; k < 40; k++) begin
      int a;
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 1) ? D180 + int'($urandom_range(1, 1000000))
                                        : -D180 - int'($urandom_range(1, 1000000));
      else
        a = int'($urandom_range(0, 2 * D180)) - D180;
      issue(a);
      wait_idle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
